// File: rtl/replay_fifo.sv
// Retransmit buffer: holds unacknowledged words in order and replays them on NACK/timeout.
// Latency: write visible in occupancy flags next cycle; replay word presented the cycle after the trigger edge.
// Backpressure: writes are dropped when full or while replaying; consumer paces replay with rd (one word per rd&rdy).
//
// Ports: clk/rst (async active-high), en (global freeze when low), wr/data_in (producer side),
//   ack/ack_seq (cumulative acknowledge), rep/tim_out (replay triggers), rd (replay pop),
//   data_out/rdy/replay_index (replay stream), seq/num_packets_to_replay/empty/full (status).
// Optional feature: define REPLAY_TIMER_EN to build the internal auto-replay timer (TIMEOUT cycles).
module replay_fifo #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int SEQ_W   = 12,
    parameter int TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     ack,
    input  logic [SEQ_W-1:0]         ack_seq,
    input  logic                     rep,
    input  logic                     tim_out,
    input  logic                     rd,
    output logic [DATA_W-1:0]        data_out,
    output logic                     rdy,
    output logic [SEQ_W-1:0]         seq,
    output logic [SEQ_W-1:0]         num_packets_to_replay,
    output logic [$clog2(DEPTH)-1:0] replay_index,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || TIMEOUT < 1) begin : g_bad_param
        $error("replay_fifo: DEPTH must be a power of 2 >= 4 and TIMEOUT >= 1");
    end

    typedef enum logic {IDLE, REPLAY} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d, rptr_q, rptr_d, ridx_q, ridx_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SEQ_W-1:0]  head_seq_q, head_seq_d, seq_q, seq_d, nrep_q, nrep_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              empty_q, empty_d, full_q, full_d;

    logic              wr_acc, ack_ok, trig, timer_exp;
    logic [SEQ_W-1:0]  ack_diff;
    logic [CW-1:0]     ack_n;
    logic [AW-1:0]     rptr_nx;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        head_seq_d = head_seq_q;
        seq_d      = seq_q;
        rptr_d     = rptr_q;
        nrep_d     = nrep_q;
        dout_d     = dout_q;
        ridx_d     = ridx_q;
        empty_d    = empty_q;
        full_d     = full_q;
        wr_acc     = 1'b0;
        ack_n      = '0;
        trig       = 1'b0;
        rptr_nx    = rptr_q + AW'(1);
        // Number of entries a cumulative ack would free (modular distance from head).
        ack_diff   = ack_seq - head_seq_q + SEQ_W'(1);
        ack_ok     = ack && (ack_diff != '0) && (ack_diff <= SEQ_W'(count_q));

        if (en) begin
            trig = rep | tim_out | timer_exp;
            if (state_q == IDLE) begin
                wr_acc = wr && (count_q != CW'(DEPTH));
                if (ack_ok) begin
                    head_d     = head_q + ack_diff[AW-1:0];
                    head_seq_d = head_seq_q + ack_diff;
                    ack_n      = ack_diff[CW-1:0];
                end
                if (wr_acc) begin
                    tail_d = tail_q + AW'(1);
                    seq_d  = seq_q + SEQ_W'(1);
                end
                count_d = count_q - ack_n + CW'(wr_acc);
                // Occupancy after this cycle's ack and write decides whether a replay starts.
                if (trig && (count_d != '0)) begin
                    state_d = REPLAY;
                    rptr_d  = head_d;
                    nrep_d  = SEQ_W'(count_d);
                    ridx_d  = head_d;
                    // Head slot may be the one being written right now (buffer was empty).
                    dout_d  = (wr_acc && (tail_q == head_d)) ? data_in : mem[head_d];
                end
            end else begin
                if (rep | tim_out) begin
                    // Rewind: no writes/acks happen in REPLAY, so head/count are current.
                    rptr_d = head_q;
                    nrep_d = SEQ_W'(count_q);
                    ridx_d = head_q;
                    dout_d = mem[head_q];
                end else if (rd) begin
                    rptr_d = rptr_nx;
                    nrep_d = nrep_q - SEQ_W'(1);
                    if (nrep_q == SEQ_W'(1)) begin
                        // Last word consumed; index/data hold their final values.
                        state_d = IDLE;
                    end else begin
                        ridx_d = rptr_nx;
                        dout_d = mem[rptr_nx];
                    end
                end
            end
            empty_d = (count_d == '0);
            full_d  = (count_d == CW'(DEPTH));
        end
    end

`ifdef REPLAY_TIMER_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;

    assign timer_exp = (state_q == IDLE) && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        timer_d = timer_q;
        if (en && (state_q == IDLE)) begin
            if ((state_d == REPLAY) || ack_ok || (count_d == '0)) begin
                timer_d = '0;
            end else if (count_q != '0) begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timer_exp = 1'b0;
`endif

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[tail_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            head_seq_q <= '0;
            seq_q      <= '0;
            rptr_q     <= '0;
            nrep_q     <= '0;
            dout_q     <= '0;
            ridx_q     <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            head_seq_q <= head_seq_d;
            seq_q      <= seq_d;
            rptr_q     <= rptr_d;
            nrep_q     <= nrep_d;
            dout_q     <= dout_d;
            ridx_q     <= ridx_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
        end
    end

    assign data_out              = dout_q;
    assign rdy                   = (state_q == REPLAY);
    assign seq                   = seq_q;
    assign num_packets_to_replay = nrep_q;
    assign replay_index          = ridx_q;
    assign empty                 = empty_q;
    assign full                  = full_q;
endmodule

// File: tb/tb_replay_fifo.sv
// Directed bench for replay_fifo: reset, replay, partial ack, full/wrap, rewind, timer.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: the bench acts as consumer, popping with rd one word per cycle.
module tb_replay_fifo;
    logic        clk = 1'b0;
    logic        rst, en, wr, ack, rep, tim_out, rd;
    logic [15:0] data_in;
    logic [11:0] ack_seq;

    logic [15:0] data_out, t_data_out;
    logic        rdy, empty, full, t_rdy, t_empty, t_full;
    logic [11:0] seq, nrep, t_seq, t_nrep;
    logic [3:0]  ridx, t_ridx;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    always #5 clk = ~clk;

    replay_fifo #(.DATA_W(16), .DEPTH(16), .SEQ_W(12), .TIMEOUT(256)) u_dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .data_in(data_in),
        .ack(ack), .ack_seq(ack_seq), .rep(rep), .tim_out(tim_out), .rd(rd),
        .data_out(data_out), .rdy(rdy), .seq(seq), .num_packets_to_replay(nrep),
        .replay_index(ridx), .empty(empty), .full(full)
    );

    replay_fifo #(.DATA_W(16), .DEPTH(16), .SEQ_W(12), .TIMEOUT(8)) u_tmr (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .data_in(data_in),
        .ack(ack), .ack_seq(ack_seq), .rep(rep), .tim_out(tim_out), .rd(rd),
        .data_out(t_data_out), .rdy(t_rdy), .seq(t_seq), .num_packets_to_replay(t_nrep),
        .replay_index(t_ridx), .empty(t_empty), .full(t_full)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [15:0] d);
        wr = 1'b1; data_in = d; tick(); wr = 1'b0;
    endtask

    task automatic do_ack(input logic [11:0] s);
        ack = 1'b1; ack_seq = s; tick(); ack = 1'b0;
    endtask

    task automatic do_rep();
        rep = 1'b1; tick(); rep = 1'b0;
    endtask

    task automatic do_pop();
        rd = 1'b1; tick(); rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; wr = 1'b0; ack = 1'b0; rep = 1'b0;
        tim_out = 1'b0; rd = 1'b0; data_in = '0; ack_seq = '0;
        tick(); tick();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_seq", seq, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_nrep", nrep, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_ridx", ridx, 0);
        rst = 1'b0; tick();

        // Basic replay of five words
        for (int i = 0; i < 5; i++) do_wr(16'(i));
        chk("basic_seq", seq, 5);
        chk("basic_empty", empty, 0);
        do_rep();
        chk("basic_rdy", rdy, 1);
        chk("basic_nrep", nrep, 5);
        for (int i = 0; i < 5; i++) begin
            chk("basic_data", data_out, 32'(i));
            chk("basic_ridx", ridx, 32'(i));
            do_pop();
        end
        chk("basic_end_rdy", rdy, 0);
        chk("basic_end_empty", empty, 0);
        chk("basic_end_nrep", nrep, 0);
        chk("basic_hold_ridx", ridx, 4);
        do_pop();
        chk("idle_rd_rdy", rdy, 0);
        chk("idle_rd_ridx", ridx, 4);

        // Partial ack, out-of-window ack, ack during replay
        do_ack(12'd2);
        chk("pack_empty", empty, 0);
        do_ack(12'd9);
        do_rep();
        chk("pack_nrep", nrep, 2);
        chk("pack_data0", data_out, 16'h3);
        chk("pack_ridx0", ridx, 3);
        do_ack(12'd4);
        chk("pack_ack_in_rep", nrep, 2);
        do_pop();
        chk("pack_data1", data_out, 16'h4);
        chk("pack_ridx1", ridx, 4);
        do_pop();
        chk("pack_end_rdy", rdy, 0);
        chk("pack_kept", empty, 0);
        do_ack(12'd4);
        chk("pack_all_acked", empty, 1);

        // Full and pointer wrap
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 0; i < 16; i++) do_wr(16'h100 + 16'(i));
        chk("full_flag", full, 1);
        chk("full_seq", seq, 16);
        do_wr(16'hDEAD);
        chk("full_drop_seq", seq, 16);
        chk("full_drop_flag", full, 1);
        do_ack(12'd15);
        chk("full_ack_empty", empty, 1);
        chk("full_ack_full", full, 0);
        for (int i = 0; i < 10; i++) do_wr(16'h200 + 16'(i));
        do_ack(12'd25);
        chk("wrap_ack_empty", empty, 1);
        for (int i = 10; i < 20; i++) do_wr(16'h200 + 16'(i));
        chk("wrap_seq", seq, 36);
        do_rep();
        chk("wrap_nrep", nrep, 10);
        do_wr(16'hBEEF);
        chk("rep_wr_seq", seq, 36);
        en = 1'b0; rd = 1'b1; tick(); rd = 1'b0; en = 1'b1;
        chk("en0_nrep", nrep, 10);
        chk("en0_data", data_out, 16'h20A);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_data", data_out, 32'(16'h20A + 16'(i)));
            chk("wrap_ridx", ridx, 32'((10 + i) % 16));
            do_pop();
        end
        chk("wrap_end_rdy", rdy, 0);

        // Rewind after two of five pops
        do_ack(12'd35);
        chk("rew_empty", empty, 1);
        for (int i = 0; i < 5; i++) do_wr(16'h30 + 16'(i));
        do_rep();
        chk("rew_data0", data_out, 16'h30);
        do_pop(); do_pop();
        chk("rew_mid_data", data_out, 16'h32);
        chk("rew_mid_nrep", nrep, 3);
        tim_out = 1'b1; tick(); tim_out = 1'b0;
        chk("rew_data", data_out, 16'h30);
        chk("rew_nrep", nrep, 5);
        chk("rew_ridx", ridx, 4);
        for (int i = 0; i < 5; i++) begin
            chk("rew_seq_data", data_out, 32'(16'h30 + 16'(i)));
            do_pop();
        end
        chk("rew_end_rdy", rdy, 0);

        // Trigger on empty buffer, then write + trigger in the same cycle
        do_ack(12'd40);
        do_rep();
        chk("empty_trig_rdy", rdy, 0);
        chk("empty_trig_nrep", nrep, 0);
        wr = 1'b1; data_in = 16'h55; rep = 1'b1; tick(); wr = 1'b0; rep = 1'b0;
        chk("wrtrig_rdy", rdy, 1);
        chk("wrtrig_data", data_out, 16'h55);
        chk("wrtrig_nrep", nrep, 1);
        chk("wrtrig_ridx", ridx, 9);
        do_pop();
        chk("wrtrig_end", rdy, 0);
        do_ack(12'd41);
        chk("wrtrig_acked", empty, 1);

        // Reset while replaying
        do_wr(16'h61); do_wr(16'h62);
        do_rep();
        chk("mid_rdy", rdy, 1);
        #2; rst = 1'b1; #1;
        chk("mid_rst_rdy", rdy, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_seq", seq, 0);
        chk("mid_rst_nrep", nrep, 0);
        tick(); rst = 1'b0; tick();

        // Timer: one write, no ack
        do_wr(16'h77);
        lat = 0;
        while (lat < 20 && !t_rdy) begin
            tick();
            lat++;
        end
        chk("tmr_seq", t_seq, 1);
        chk("tmr_empty", t_empty, 0);
        chk("tmr_full", t_full, 0);
        chk("tmr_main_rdy", rdy, 0);
`ifdef REPLAY_TIMER_EN
        chk("tmr_latency", lat, 8);
        chk("tmr_rdy", t_rdy, 1);
        chk("tmr_data", t_data_out, 16'h77);
        chk("tmr_nrep", t_nrep, 1);
        chk("tmr_ridx", t_ridx, 0);
`else
        chk("tmr_rdy", t_rdy, 0);
        chk("tmr_nrep", t_nrep, 0);
        chk("tmr_data", t_data_out, 0);
        chk("tmr_ridx", t_ridx, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/replay_fifo.md
REPLAY_FIFO -- requirements
Module: replay_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16: packet word width.
REQ-002 SHALL have parameter DEPTH, default 16: entries; power of 2, >= 4.
REQ-003 SHALL have parameter SEQ_W, default 12: sequence number width.
REQ-004 SHALL have parameter TIMEOUT, default 256: cycles to auto-replay (used only per REQ-028).
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  global enable.
- wr  in  1  write request.
- data_in  in  DATA_W  write data.
- ack  in  1  acknowledge strobe.
- ack_seq  in  SEQ_W  highest sequence acknowledged.
- rep  in  1  NACK, replay request.
- tim_out  in  1  external timeout, replay request.
- rd  in  1  consumer pop during replay.
- data_out  out  DATA_W  replay word.
- rdy  out  1  data_out valid.
- seq  out  SEQ_W  sequence number of next write.
- num_packets_to_replay  out  SEQ_W  words remaining in current replay.
- replay_index  out  log2(DEPTH)  buffer slot being presented.
- empty  out  1  no unacknowledged entries.
- full  out  1  DEPTH unacknowledged entries.

Function
REQ-006 SHALL store up to DEPTH unacknowledged words in circular order; head = oldest, tail = next free slot.
REQ-007 SHALL, when en=0, freeze all state; inputs are ignored and outputs hold.
REQ-008 SHALL accept a write when wr&en&!full and state=IDLE: store data_in at tail, advance tail, and increment seq modulo 2^SEQ_W.
REQ-009 SHALL ignore writes when full or in REPLAY; seq and contents stay unchanged.
REQ-010 SHALL keep head_seq, the sequence of the head entry; the entry at offset k carries head_seq+k.
REQ-011 SHALL, on ack&en in IDLE, compute n = ack_seq-head_seq+1 (mod 2^SEQ_W); if 1 <= n <= occupancy, advance head and head_seq by n; otherwise ignore.
REQ-012 SHALL ignore ack while in REPLAY.
REQ-013 SHALL use states IDLE and REPLAY.
REQ-014 SHALL go IDLE->REPLAY when en&(rep|tim_out|internal expiry) and occupancy>0 after that cycle's write/ack.
- Replay pointer loads head; num_packets_to_replay loads that occupancy.
- Same-cycle write is included; same-cycle ack is applied first.
REQ-015 SHALL stay in IDLE, with no replay, if a trigger arrives with occupancy 0.
REQ-016 SHALL, in REPLAY, drive rdy=1, data_out=mem[replay pointer], and replay_index=replay pointer, starting the cycle after the trigger edge.
REQ-017 SHALL, on rd&rdy, advance the pointer (wrapping at DEPTH), decrement num_packets_to_replay, and present the next word the following cycle with no bubble.
REQ-018 SHALL, on the pop that takes num_packets_to_replay to 0, return to IDLE with rdy=0; entries are retained until acknowledged.
REQ-019 SHALL restart the replay from head (rewind) on rep or tim_out during REPLAY, reloading the count.
REQ-020 SHALL ignore rd in IDLE.
REQ-021 SHALL drive empty = (occupancy==0) and full = (occupancy==DEPTH), both registered and correct the cycle after the causing edge.
REQ-022 SHALL hold replay_index and data_out at their last values in IDLE.

Reset
REQ-023 SHALL, on rst=1, immediately clear head, tail, head_seq, seq, the timer, and the replay pointer, and set state=IDLE.
REQ-024 SHALL drive reset output values: data_out=0, rdy=0, seq=0, num_packets_to_replay=0, replay_index=0, empty=1, full=0.
REQ-025 SHALL, on rst mid-replay, abort the replay; all stored entries are discarded.
REQ-026 SHALL not clear memory contents on reset.

Configuration
REQ-027 SHALL compile the internal replay timer only when macro REPLAY_TIMER_EN is defined.
REQ-028 SHALL, with REPLAY_TIMER_EN defined, run the timer as follows:
- Increments each en cycle in IDLE with occupancy>0.
- Clears on an ack that frees >= 1 entry, on entry to REPLAY, and on occupancy 0.
- When it reaches TIMEOUT-1, it triggers replay exactly as tim_out does.
REQ-029 SHALL, without REPLAY_TIMER_EN, contain no timer logic and ignore TIMEOUT; only rep and tim_out trigger replay.

Verification
REQ-030 SHALL pass a reset test: rst pulse -> empty=1, full=0, seq=0, rdy=0, num_packets_to_replay=0.
REQ-031 SHALL pass a basic replay test: write 0x0..0x4, then rep -> next cycle rdy=1, num_packets_to_replay=5, data_out=0x0; five rd pops yield 0x0..0x4 with replay_index 0..4, then rdy=0 and empty=0.
REQ-032 SHALL pass a partial-ack test: write 0x0..0x4, then ack_seq=2 -> occupancy 2; rep replays 0x3, 0x4 only; ack_seq=9 (out of window) is ignored.
REQ-033 SHALL pass a full/wrap test with DEPTH=16: 16 writes -> full=1, seq=16; a 17th write is ignored; ack_seq=15 -> empty=1; 20 further writes plus acks wrap the pointers and a replay returns correct data.
REQ-034 SHALL pass a rewind test: rep after 2 of 5 pops -> replay restarts at the head word, num_packets_to_replay=5.
REQ-035 SHALL pass a timer test with REPLAY_TIMER_EN and TIMEOUT=8: one write and no ack -> rdy rises 8 cycles after the write; without the macro, rdy stays 0.
